// File: rtl/nec_ir_transmitter.sv
// NEC infrared transmitter with Wishbone register interface.
// Serialises NEC frames or repeat codes with optional carrier and inversion.
module nec_ir_transmitter #(
    parameter int PSIZE = 20,
    parameter int CSIZE = 12,
    parameter int ASIZE = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        ir_out,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE,
        LEADER_MARK,
        LEADER_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } state_t;

    localparam logic [ASIZE-1:0] OFF_CTRL   = ASIZE'(0);
    localparam logic [ASIZE-1:0] OFF_PRESC  = ASIZE'(1);
    localparam logic [ASIZE-1:0] OFF_CARR   = ASIZE'(2);
    localparam logic [ASIZE-1:0] OFF_TX     = ASIZE'(3);
    localparam logic [ASIZE-1:0] OFF_STATUS = ASIZE'(4);

    // programmer-visible registers
    logic [4:0]       ctrl;
    logic [PSIZE-1:0] prescaler;
    logic [CSIZE-1:0] carrier;
    logic [31:0]      tx_reg;
    logic             busy;
    logic             done;
    logic             overflow;

    // frame captured at acceptance
    logic [31:0] payload;
    logic        rpt;

    logic enable;
    logic irq_en;
    logic carrier_en;
    logic invert;
    logic ext_addr;

    assign enable     = ctrl[0];
    assign irq_en     = ctrl[1];
    assign carrier_en = ctrl[2];
    assign invert     = ctrl[3];
    assign ext_addr   = ctrl[4];

    logic             req;
    logic [ASIZE-1:0] off;
    logic             wr;
    logic             tx_wr;
    logic             st_wr;
    logic             accept;
    logic             abort;
    logic             finish;
    logic [31:0]      rdata;
    logic [31:0]      frame_bits;
    logic             unused_adr;

    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign off    = wbs_adr_i[ASIZE+1:2];
    assign wr     = req & wbs_we_i & (wbs_sel_i == 4'hF);
    assign tx_wr  = wr & (off == OFF_TX);
    assign st_wr  = wr & (off == OFF_STATUS);
    assign accept = tx_wr & enable & ~busy;
    assign abort  = busy & ~enable;
    assign irq    = done & irq_en;

    assign unused_adr = ^{wbs_adr_i[31:ASIZE+2], wbs_adr_i[1:0]};

    always_comb begin
        frame_bits = {~wbs_dat_i[23:16], wbs_dat_i[23:16],
                      ~wbs_dat_i[7:0], wbs_dat_i[7:0]};
        if (ext_addr) begin
            frame_bits = {~wbs_dat_i[23:16], wbs_dat_i[23:16],
                          wbs_dat_i[15:0]};
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = {27'd0, ctrl};
            OFF_PRESC:  rdata[PSIZE-1:0] = prescaler;
            OFF_CARR:   rdata[CSIZE-1:0] = carrier;
            OFF_TX:     rdata = tx_reg;
            OFF_STATUS: rdata = {29'd0, overflow, done, busy};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl      <= '0;
            prescaler <= '0;
            carrier   <= '0;
            tx_reg    <= '0;
            payload   <= '0;
            rpt       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            if (wr) begin
                case (off)
                    OFF_CTRL:  ctrl      <= wbs_dat_i[4:0];
                    OFF_PRESC: prescaler <= wbs_dat_i[PSIZE-1:0];
                    OFF_CARR:  carrier   <= wbs_dat_i[CSIZE-1:0];
                    OFF_TX:    tx_reg    <= wbs_dat_i;
                    default:   ;
                endcase
            end
            if (accept) begin
                payload <= frame_bits;
                rpt     <= wbs_dat_i[31];
                busy    <= 1'b1;
            end else if (finish || abort) begin
                busy <= 1'b0;
            end
            // a completing frame beats a simultaneous clear
            if (finish) begin
                done <= 1'b1;
            end else if (st_wr && wbs_dat_i[1]) begin
                done <= 1'b0;
            end
            if (tx_wr && !accept) begin
                overflow <= 1'b1;
            end else if (st_wr && wbs_dat_i[2]) begin
                overflow <= 1'b0;
            end
        end
    end

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       slot_cnt;
    logic [4:0]       slot_nxt;
    logic [4:0]       slot_len;
    logic [4:0]       bit_idx;
    logic [4:0]       bit_nxt;
    logic [31:0]      shreg;
    logic [31:0]      shreg_nxt;
    logic [PSIZE-1:0] pcnt;
    logic [PSIZE-1:0] pcnt_nxt;
    logic [PSIZE-1:0] presc_act;
    logic [PSIZE-1:0] presc_act_nxt;
    logic [CSIZE-1:0] ccnt;
    logic [CSIZE-1:0] ccnt_nxt;
    logic [CSIZE-1:0] carr_act;
    logic [CSIZE-1:0] carr_act_nxt;
    logic             phase;
    logic             phase_nxt;
    logic             level_nxt;
    logic             tick;
    logic             last;
    logic             mark_now;
    logic             mark_nxt;

    function automatic logic is_mark(input state_t s);
        return (s == LEADER_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    assign tick     = (state != IDLE) && (pcnt == presc_act);
    assign last     = tick && (slot_cnt == slot_len);
    assign mark_now = is_mark(state);
    assign mark_nxt = is_mark(state_nxt);

    always_comb begin
        slot_len = 5'd0;
        case (state)
            LEADER_MARK:  slot_len = 5'd15;
            LEADER_SPACE: slot_len = rpt ? 5'd3 : 5'd7;
            BIT_SPACE:    slot_len = shreg[0] ? 5'd2 : 5'd0;
            default:      slot_len = 5'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        finish    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (busy) begin
                        state_nxt = LEADER_MARK;
                        shreg_nxt = payload;
                        bit_nxt   = 5'd0;
                    end
                end
                LEADER_MARK: begin
                    if (last) state_nxt = LEADER_SPACE;
                end
                LEADER_SPACE: begin
                    if (last) state_nxt = rpt ? STOP_MARK : BIT_MARK;
                end
                BIT_MARK: begin
                    if (last) state_nxt = BIT_SPACE;
                end
                BIT_SPACE: begin
                    if (last) begin
                        shreg_nxt = {1'b0, shreg[31:1]};
                        bit_nxt   = bit_idx + 5'd1;
                        state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                end
                STOP_MARK: begin
                    if (last) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        slot_nxt = slot_cnt;
        if (state_nxt != state) begin
            slot_nxt = 5'd0;
        end else if (tick) begin
            slot_nxt = slot_cnt + 5'd1;
        end
        // prescaler counter held at zero outside a frame
        pcnt_nxt      = pcnt + PSIZE'(1);
        presc_act_nxt = presc_act;
        if (state == IDLE || state_nxt == IDLE || tick) begin
            pcnt_nxt = '0;
        end
        if (state == IDLE || tick) begin
            presc_act_nxt = prescaler;
        end
    end

    always_comb begin
        ccnt_nxt     = '0;
        phase_nxt    = phase;
        carr_act_nxt = carrier;
        if (mark_nxt && !mark_now) begin
            phase_nxt = 1'b1;
        end else if (mark_nxt) begin
            carr_act_nxt = carr_act;
            ccnt_nxt     = ccnt + CSIZE'(1);
            if (ccnt == carr_act) begin
                ccnt_nxt     = '0;
                phase_nxt    = ~phase;
                carr_act_nxt = carrier;
            end
        end
        level_nxt = 1'b0;
        if (mark_nxt) begin
            level_nxt = carrier_en ? phase_nxt : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            pcnt      <= '0;
            presc_act <= '0;
            ccnt      <= '0;
            carr_act  <= '0;
            phase     <= 1'b0;
            ir_out    <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot_cnt  <= slot_nxt;
            bit_idx   <= bit_nxt;
            shreg     <= shreg_nxt;
            pcnt      <= pcnt_nxt;
            presc_act <= presc_act_nxt;
            ccnt      <= ccnt_nxt;
            carr_act  <= carr_act_nxt;
            phase     <= phase_nxt;
            ir_out    <= level_nxt ^ invert;
        end
    end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Self-checking bench for nec_ir_transmitter: register table, directed
// frames and randomised frames compared with a slot-level waveform model.
module tb_nec_ir_transmitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] adr = '0;
    logic        we = 1'b0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_r;
    logic        ack;
    logic        ir_out;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit exp_w[$];

    nec_ir_transmitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_adr_i (adr),
        .wbs_we_i  (we),
        .wbs_dat_i (dat_w),
        .wbs_sel_i (sel),
        .wbs_dat_o (dat_r),
        .wbs_ack_o (ack),
        .ir_out    (ir_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input bit wr, input int off, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr;
        adr   = off << 2;
        dat_w = d;
        sel   = s;
        @(negedge clk);
        chk("ack", {31'd0, ack}, 32'd1);
        q   = dat_r;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_write(input int off, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, off, d, 4'hF, q);
    endtask

    task automatic wb_read(input int off, output logic [31:0] q);
        wb_xfer(1'b0, off, 32'd0, 4'hF, q);
    endtask

    task automatic add_vec(input bit wr, input int off, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] e,
                           input string name);
        vec_t v;
        v.wr = wr;
        v.off = off;
        v.dat = d;
        v.sel = s;
        v.exp = e;
        v.name = name;
        vt.push_back(v);
    endtask

    // Expand a mark or space of n slots into per-clock expected levels.
    task automatic add_seg(input bit mark, input int n, input int p,
                           input int c, input bit car, input bit inv);
        bit lv;
        for (int i = 0; i < n * (p + 1); i++) begin
            lv = 1'b0;
            if (mark) lv = car ? (((i / (c + 1)) % 2) == 0) : 1'b1;
            exp_w.push_back(lv ^ inv);
        end
    endtask

    task automatic build_wave(input logic [4:0] ctrl, input int p,
                              input int c, input logic [31:0] tx);
        logic [31:0] pl;
        logic [7:0]  cmd;
        bit car;
        bit inv;
        cmd = tx[23:16];
        car = ctrl[2];
        inv = ctrl[3];
        if (ctrl[4]) pl = {~cmd, cmd, tx[15:0]};
        else pl = {~cmd, cmd, ~tx[7:0], tx[7:0]};
        exp_w.delete();
        add_seg(1'b1, 16, p, c, car, inv);
        if (tx[31]) begin
            add_seg(1'b0, 4, p, c, car, inv);
        end else begin
            add_seg(1'b0, 8, p, c, car, inv);
            for (int b = 0; b < 32; b++) begin
                add_seg(1'b1, 1, p, c, car, inv);
                add_seg(1'b0, pl[b] ? 3 : 1, p, c, car, inv);
            end
        end
        add_seg(1'b1, 1, p, c, car, inv);
    endtask

    task automatic check_wave(input string name, input bit irq_en,
                              input bit inv);
        int n;
        int bad;
        int first;
        bit e_ir;
        bit e_irq;
        logic a_ir;
        logic a_irq;
        n = exp_w.size();
        bad = 0;
        first = -1;
        a_ir = 1'b0;
        a_irq = 1'b0;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            e_ir  = (i < n) ? exp_w[i] : inv;
            e_irq = (i < n) ? 1'b0 : irq_en;
            if (ir_out !== e_ir || irq !== e_irq) begin
                bad++;
                if (first < 0) begin
                    first = i;
                    a_ir = ir_out;
                    a_irq = irq;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d bad cycles, first at %0d ir_out=%b irq=%b",
                     name, bad, first, a_ir, a_irq);
        end
    endtask

    task automatic start_frame(input logic [4:0] ctrl, input int p,
                               input int c, input logic [31:0] tx);
        wb_write(1, p);
        wb_write(2, c);
        wb_write(0, {27'd0, ctrl});
        build_wave(ctrl, p, c, tx);
        wb_write(3, tx);
    endtask

    task automatic finish_frame(input string name, input logic [31:0] st);
        logic [31:0] q;
        wb_read(4, q);
        chk({name, " status"}, q, st);
        wb_write(4, 32'h6);
        chk({name, " irq clr"}, {31'd0, irq}, 32'd0);
        wb_read(4, q);
        chk({name, " status clr"}, q, 32'd0);
    endtask

    task automatic run_frame(input string name, input logic [4:0] ctrl,
                             input int p, input int c, input logic [31:0] tx);
        start_frame(ctrl, p, c, tx);
        check_wave({name, " wave"}, ctrl[1], ctrl[3]);
        finish_frame(name, 32'h2);
    endtask

    initial begin
        logic [31:0] q;
        logic [4:0]  rc;
        logic [31:0] rtx;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst ir_out", {31'd0, ir_out}, 32'd0);
        chk("rst irq", {31'd0, irq}, 32'd0);
        chk("rst ack", {31'd0, ack}, 32'd0);
        chk("rst dat_o", dat_r, 32'd0);

        add_vec(0, 0, 0, 4'hF, 32'h0, "rst ctrl");
        add_vec(0, 1, 0, 4'hF, 32'h0, "rst presc");
        add_vec(0, 2, 0, 4'hF, 32'h0, "rst carr");
        add_vec(0, 3, 0, 4'hF, 32'h0, "rst tx");
        add_vec(0, 4, 0, 4'hF, 32'h0, "rst status");
        add_vec(1, 0, 32'h1F, 4'hF, 0, "");
        add_vec(0, 0, 0, 4'hF, 32'h1F, "ctrl rw");
        add_vec(1, 0, 32'h00, 4'h3, 0, "");
        add_vec(0, 0, 0, 4'hF, 32'h1F, "ctrl sel3");
        add_vec(1, 1, 32'hFFFF_FFFF, 4'hF, 0, "");
        add_vec(0, 1, 0, 4'hF, 32'h000F_FFFF, "presc width");
        add_vec(1, 2, 32'hFFFF_FFFF, 4'hF, 0, "");
        add_vec(0, 2, 0, 4'hF, 32'h0000_0FFF, "carr width");
        add_vec(1, 7, 32'h1234_5678, 4'hF, 0, "");
        add_vec(0, 7, 0, 4'hF, 32'h0, "unmapped 7");
        add_vec(1, 5, 32'hFFFF_FFFF, 4'hF, 0, "");
        add_vec(0, 5, 0, 4'hF, 32'h0, "unmapped 5");
        add_vec(1, 0, 32'h00, 4'hF, 0, "");
        add_vec(1, 3, 32'h1234_5678, 4'hF, 0, "");
        add_vec(0, 4, 0, 4'hF, 32'h4, "ovf disabled");
        add_vec(0, 3, 0, 4'hF, 32'h1234_5678, "tx readback");
        add_vec(1, 4, 32'h4, 4'hF, 0, "");
        add_vec(0, 4, 0, 4'hF, 32'h0, "ovf clear");

        foreach (vt[i]) begin
            wb_xfer(vt[i].wr, vt[i].off, vt[i].dat, vt[i].sel, q);
            if (!vt[i].wr) chk(vt[i].name, q, vt[i].exp);
        end

        run_frame("nec", 5'h03, 9, 0, 32'h0001_0000);
        run_frame("rpt", 5'h03, 0, 0, 32'h8000_0000);
        run_frame("car", 5'h07, 11, 2, 32'h00A5_1234);
        run_frame("inv", 5'h0B, 2, 0, 32'h005A_00C3);
        run_frame("ext", 5'h13, 1, 0, 32'h0033_BEEF);

        start_frame(5'h03, 1, 0, 32'h00C4_0017);
        fork
            check_wave("ovf wave", 1'b1, 1'b0);
            begin
                repeat (40) @(negedge clk);
                wb_write(3, 32'h00FF_00FF);
            end
        join
        finish_frame("ovf", 32'h6);

        start_frame(5'h01, 3, 0, 32'h0011_0022);
        repeat (10) @(negedge clk);
        wb_write(0, 32'h0);
        @(negedge clk);
        chk("abort ir_out", {31'd0, ir_out}, 32'd0);
        wb_read(4, q);
        chk("abort status", q, 32'h0);

        start_frame(5'h03, 3, 0, 32'h0011_0022);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst ir_out", {31'd0, ir_out}, 32'd0);
        chk("mid rst irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        wb_read(0, q);
        chk("mid rst ctrl", q, 32'h0);
        wb_read(4, q);
        chk("mid rst status", q, 32'h0);

        for (int k = 0; k < 6; k++) begin
            rc = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 2'b11};
            rtx = $urandom;
            rtx[30:24] = 7'd0;
            rtx[31] = ($urandom_range(0, 3) == 0);
            run_frame("rand", rc, $urandom_range(0, 3),
                      $urandom_range(0, 3), rtx);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
